// File: rtl/enc16_dual_rail.sv
// Dual-rail 16-to-4 one-hot encoder with a valid/ready handshake.
// Rejected input words pulse err and bump a saturating error counter.
module enc16_dual_rail #(
    parameter bit REQUIRE_SPACER = 1'b1
) (
    input  logic        CK,
    input  logic        RN,
    input  logic [15:0] y,
    input  logic [15:0] ybar,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  q,
    output logic [3:0]  qbar,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OUT    = 2'd1,
        SPACER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  q_q, q_d;
    logic [3:0]  qbar_q, qbar_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        xfer;
    logic        is_code;
    logic        is_spacer;
    logic [3:0]  idx;

    assign is_spacer = (y == 16'h0000) && (ybar == 16'h0000);
    assign is_code   = (y != 16'h0000)
                     && ((y & (y - 16'd1)) == 16'h0000)
                     && (ybar == ~y);

    always_comb begin
        idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (y[i]) idx = i[3:0];
        end
    end

    assign in_ready = (state_q != OUT);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        qbar_d    = qbar_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (xfer && is_code) begin
                    state_d = OUT;
                    q_d     = idx;
                    qbar_d  = ~idx;
                end else if (xfer && !is_spacer) begin
                    err_d = 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = REQUIRE_SPACER ? SPACER : IDLE;
                    q_d     = 4'h0;
                    qbar_d  = 4'h0;
                end
            end
            SPACER: begin
                if (xfer && is_spacer) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                q_d     = 4'h0;
                qbar_d  = 4'h0;
            end
        endcase
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q   <= IDLE;
            q_q       <= 4'h0;
            qbar_q    <= 4'h0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            qbar_q    <= qbar_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign q         = q_q;
    assign qbar      = qbar_q;
    assign out_valid = (state_q == OUT);
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_enc16_dual_rail.sv
// Directed bench for enc16_dual_rail; a second instance runs
// with the spacer requirement disabled.
module tb_enc16_dual_rail;

    logic        CK = 1'b0;
    logic        RN;
    logic [15:0] y, ybar;
    logic        in_valid, out_ready;

    logic        in_ready, out_valid, err;
    logic [3:0]  q, qbar;
    logic [7:0]  err_cnt;

    logic        in_ready0, out_valid0, err0;
    logic [3:0]  q0, qbar0;
    logic [7:0]  err_cnt0;

    int errors = 0;
    int checks = 0;

    always #5 CK = ~CK;

    enc16_dual_rail #(.REQUIRE_SPACER(1'b1)) u_dut (
        .CK(CK), .RN(RN), .y(y), .ybar(ybar),
        .in_valid(in_valid), .in_ready(in_ready),
        .q(q), .qbar(qbar), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .err_cnt(err_cnt)
    );

    enc16_dual_rail #(.REQUIRE_SPACER(1'b0)) u_dut0 (
        .CK(CK), .RN(RN), .y(y), .ybar(ybar),
        .in_valid(in_valid), .in_ready(in_ready0),
        .q(q0), .qbar(qbar0), .out_valid(out_valid0),
        .out_ready(out_ready), .err(err0), .err_cnt(err_cnt0)
    );

    task automatic step();
        @(posedge CK);
        @(negedge CK);
    endtask

    task automatic drive(input logic v, input logic [15:0] t,
                         input logic [15:0] c);
        in_valid = v;
        y        = t;
        ybar     = c;
    endtask

    task automatic test_reset();
        RN = 1'b0; out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        step(); step();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid got=%b exp=0", out_valid); end
        if (q !== 4'h0) begin errors++;
            $display("FAIL rst_q got=%h exp=0", q); end
        if (qbar !== 4'h0) begin errors++;
            $display("FAIL rst_qbar got=%h exp=0", qbar); end
        if (err !== 1'b0) begin errors++;
            $display("FAIL rst_err got=%b exp=0", err); end
        if (err_cnt !== 8'h00) begin errors++;
            $display("FAIL rst_cnt got=%h exp=00", err_cnt); end
        RN = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_rdy got=%b exp=1", in_ready); end
    endtask

    task automatic test_codeword();
        drive(1'b1, 16'h0400, 16'hFBFF);
        step();
        drive(1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            checks += 4;
            if (out_valid !== 1'b1) begin errors++;
                $display("FAIL cw_valid[%0d] got=%b exp=1", i, out_valid); end
            if (q !== 4'hA) begin errors++;
                $display("FAIL cw_q[%0d] got=%h exp=a", i, q); end
            if (qbar !== 4'h5) begin errors++;
                $display("FAIL cw_qbar[%0d] got=%h exp=5", i, qbar); end
            if (in_ready !== 1'b0) begin errors++;
                $display("FAIL cw_rdy[%0d] got=%b exp=0", i, in_ready); end
            if (i < 3) step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL cons_valid got=%b exp=0", out_valid); end
        if (q !== 4'h0) begin errors++;
            $display("FAIL cons_q got=%h exp=0", q); end
        if (qbar !== 4'h0) begin errors++;
            $display("FAIL cons_qbar got=%h exp=0", qbar); end
        if (in_ready !== 1'b1) begin errors++;
            $display("FAIL cons_rdy got=%b exp=1", in_ready); end
        drive(1'b1, 16'h0000, 16'h0000);
        step();
        drive(1'b1, 16'h0001, 16'hFFFE);
        step();
        drive(1'b0, 16'h0, 16'h0);
        checks += 4;
        if (out_valid !== 1'b1) begin errors++;
            $display("FAIL cw0_valid got=%b exp=1", out_valid); end
        if (q !== 4'h0) begin errors++;
            $display("FAIL cw0_q got=%h exp=0", q); end
        if (qbar !== 4'hF) begin errors++;
            $display("FAIL cw0_qbar got=%h exp=f", qbar); end
        if (err !== 1'b0) begin errors++;
            $display("FAIL cw0_err got=%b exp=0", err); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(1'b1, 16'h0000, 16'h0000);
        step();
        drive(1'b0, 16'h0, 16'h0);
    endtask

    task automatic test_invalid();
        drive(1'b1, 16'h0003, 16'hFFFC);
        step();
        drive(1'b0, 16'h0, 16'h0);
        checks += 3;
        if (err !== 1'b1) begin errors++;
            $display("FAIL inv1_err got=%b exp=1", err); end
        if (err_cnt !== 8'd1) begin errors++;
            $display("FAIL inv1_cnt got=%0d exp=1", err_cnt); end
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL inv1_valid got=%b exp=0", out_valid); end
        step();
        checks++;
        if (err !== 1'b0) begin errors++;
            $display("FAIL inv1_pulse got=%b exp=0", err); end
        drive(1'b1, 16'h0010, 16'h0010);
        step();
        drive(1'b0, 16'h0, 16'h0);
        checks += 3;
        if (err !== 1'b1) begin errors++;
            $display("FAIL inv2_err got=%b exp=1", err); end
        if (err_cnt !== 8'd2) begin errors++;
            $display("FAIL inv2_cnt got=%0d exp=2", err_cnt); end
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL inv2_valid got=%b exp=0", out_valid); end
        step();
    endtask

    task automatic test_spacer_required();
        drive(1'b1, 16'h0040, 16'hFFBF);
        step();
        drive(1'b0, 16'h0, 16'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(1'b1, 16'h8000, 16'h7FFF);
        step();
        drive(1'b0, 16'h0, 16'h0);
        checks += 3;
        if (err !== 1'b1) begin errors++;
            $display("FAIL nosp_err got=%b exp=1", err); end
        if (err_cnt !== 8'd3) begin errors++;
            $display("FAIL nosp_cnt got=%0d exp=3", err_cnt); end
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL nosp_valid got=%b exp=0", out_valid); end
        drive(1'b1, 16'h8000, 16'h7FFF);
        step();
        drive(1'b0, 16'h0, 16'h0);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL nosp2_valid got=%b exp=0", out_valid); end
        if (err_cnt !== 8'd4) begin errors++;
            $display("FAIL nosp2_cnt got=%0d exp=4", err_cnt); end
        drive(1'b1, 16'h0000, 16'h0000);
        step();
        drive(1'b1, 16'h8000, 16'h7FFF);
        step();
        drive(1'b0, 16'h0, 16'h0);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++;
            $display("FAIL sp_valid got=%b exp=1", out_valid); end
        if (q !== 4'hF) begin errors++;
            $display("FAIL sp_q got=%h exp=f", q); end
        if (qbar !== 4'h0) begin errors++;
            $display("FAIL sp_qbar got=%h exp=0", qbar); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(1'b1, 16'h0000, 16'h0000);
        step();
        drive(1'b0, 16'h0, 16'h0);
    endtask

    task automatic test_saturate();
        logic [7:0] exp_cnt;
        RN = 1'b0;
        step();
        RN = 1'b1;
        drive(1'b1, 16'h0005, 16'hFFFA);
        for (int i = 1; i <= 300; i++) begin
            step();
            exp_cnt = (i < 255) ? i[7:0] : 8'hFF;
            checks += 2;
            if (err !== 1'b1) begin errors++;
                $display("FAIL sat_err[%0d] got=%b exp=1", i, err); end
            if (err_cnt !== exp_cnt) begin errors++;
                $display("FAIL sat_cnt[%0d] got=%h exp=%h",
                         i, err_cnt, exp_cnt); end
        end
        drive(1'b0, 16'h0, 16'h0);
        step();
        checks += 2;
        if (err !== 1'b0) begin errors++;
            $display("FAIL sat_end_err got=%b exp=0", err); end
        if (err_cnt !== 8'hFF) begin errors++;
            $display("FAIL sat_end_cnt got=%h exp=ff", err_cnt); end
    endtask

    task automatic test_reset_in_out();
        drive(1'b1, 16'h0080, 16'hFF7F);
        step();
        drive(1'b0, 16'h0, 16'h0);
        checks += 2;
        if (q !== 4'h7) begin errors++;
            $display("FAIL ro_q got=%h exp=7", q); end
        if (qbar !== 4'h8) begin errors++;
            $display("FAIL ro_qbar got=%h exp=8", qbar); end
        RN = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 16'h0002, 16'hFFFD);
        step();
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        checks += 4;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL ro_valid got=%b exp=0", out_valid); end
        if (q !== 4'h0) begin errors++;
            $display("FAIL ro_q0 got=%h exp=0", q); end
        if (qbar !== 4'h0) begin errors++;
            $display("FAIL ro_qbar0 got=%h exp=0", qbar); end
        if (err_cnt !== 8'h00) begin errors++;
            $display("FAIL ro_cnt got=%h exp=00", err_cnt); end
        RN = 1'b1;
        step();
        checks += 2;
        if (in_ready !== 1'b1) begin errors++;
            $display("FAIL ro_rdy got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL ro_valid2 got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        RN = 1'b0;
        step();
        RN = 1'b1;
        drive(1'b1, 16'h0020, 16'hFFDF);
        step();
        drive(1'b0, 16'h0, 16'h0);
        checks += 2;
        if (q0 !== 4'h5) begin errors++;
            $display("FAIL b2b_q0 got=%h exp=5", q0); end
        if (q !== 4'h5) begin errors++;
            $display("FAIL b2b_q got=%h exp=5", q); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks += 2;
        if (in_ready0 !== 1'b1) begin errors++;
            $display("FAIL b2b_rdy0 got=%b exp=1", in_ready0); end
        if (out_valid0 !== 1'b0) begin errors++;
            $display("FAIL b2b_valid0 got=%b exp=0", out_valid0); end
        drive(1'b1, 16'h0100, 16'hFEFF);
        step();
        drive(1'b0, 16'h0, 16'h0);
        checks += 6;
        if (out_valid0 !== 1'b1) begin errors++;
            $display("FAIL b2b_v0 got=%b exp=1", out_valid0); end
        if (q0 !== 4'h8) begin errors++;
            $display("FAIL b2b_q0b got=%h exp=8", q0); end
        if (qbar0 !== 4'h7) begin errors++;
            $display("FAIL b2b_qbar0 got=%h exp=7", qbar0); end
        if (err0 !== 1'b0) begin errors++;
            $display("FAIL b2b_err0 got=%b exp=0", err0); end
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_v1 got=%b exp=0", out_valid); end
        if (err !== 1'b1) begin errors++;
            $display("FAIL b2b_err1 got=%b exp=1", err); end
    endtask

    initial begin
        test_reset();
        test_codeword();
        test_invalid();
        test_spacer_required();
        test_saturate();
        test_reset_in_out();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enc16_dual_rail.md
ENC16_DUAL_RAIL -- requirements
Module: enc16_dual_rail

Interface
REQ-001 Parameter: REQUIRE_SPACER, default 1, 1 = an all-zero spacer word is mandatory between codewords; 0 = back-to-back codewords allowed.
REQ-002 Clocking SHALL be one clock CK; reset RN SHALL be synchronous and active-low.
REQ-003 CK  in  1  rising-edge clock.
REQ-004 RN  in  1  synchronous active-low reset.
REQ-005 y  in  16  true rail of the one-hot decoder word.
REQ-006 ybar  in  16  complement rail of the decoder word.
REQ-007 in_valid  in  1  input word present.
REQ-008 in_ready  out  1  block accepts the input word this cycle.
REQ-009 q  out  4  binary index of the set bit of y.
REQ-010 qbar  out  4  complement rail of q.
REQ-011 out_valid  out  1  q/qbar hold a codeword.
REQ-012 out_ready  in  1  consumer accepts q/qbar.
REQ-013 err  out  1  one-cycle pulse on a rejected input word.
REQ-014 err_cnt  out  8  saturating count of rejected words.

Function
REQ-015 Word classes SHALL be defined as follows: CODEWORD = exactly one bit of y set and ybar == ~y; SPACER = y == 0 and ybar == 0; INVALID = any other combination.
REQ-016 The FSM SHALL have the states IDLE, OUT and SPACER; in_ready SHALL be 1 in IDLE and SPACER and 0 in OUT, decoded from state only.
REQ-017 An input transfer SHALL occur on a rising edge with in_valid && in_ready; words are classified only on a transfer.
REQ-018 IDLE, CODEWORD transfer: the block SHALL register q = index of the set y bit and qbar = ~q, go to OUT, and drive out_valid = 1 from the next cycle (latency 1).
REQ-019 IDLE, SPACER transfer: the word SHALL be discarded and the state SHALL stay IDLE with no err.
REQ-020 IDLE, INVALID transfer: the block SHALL pulse err for exactly the following cycle, increment err_cnt, stay IDLE, and produce no output.
REQ-021 OUT: q, qbar and out_valid SHALL hold stable until out_ready = 1 on a rising edge.
REQ-022 OUT with out_ready = 1: the next state SHALL be SPACER if REQUIRE_SPACER = 1, else IDLE, and out_valid, q and qbar SHALL be 0 from the next cycle.
REQ-023 SPACER, SPACER transfer: the next state SHALL be IDLE.
REQ-024 SPACER, CODEWORD or INVALID transfer: the word SHALL be rejected (err pulse, err_cnt increment), the state SHALL stay SPACER, and no output is produced.
REQ-025 Whenever out_valid = 0, q and qbar SHALL both be 4'h0 (output spacer); whenever out_valid = 1, qbar == ~q.
REQ-026 err_cnt SHALL saturate at 8'hFF; further rejections still pulse err but leave err_cnt at 8'hFF.
REQ-027 in_valid with in_ready = 0 SHALL have no effect; input words are not stored while in OUT.
REQ-028 q and qbar SHALL be driven directly from flops, with no combinational path from y/ybar to q/qbar.
REQ-029 Throughput SHALL be at most one codeword every 3 cycles with REQUIRE_SPACER = 1 and every 2 cycles with REQUIRE_SPACER = 0.

Reset
REQ-030 RN = 0 at a rising edge SHALL force, from the next cycle: state IDLE, out_valid = 0, q = 4'h0, qbar = 4'h0, err = 0, err_cnt = 8'h00.
REQ-031 Reset SHALL override any transfer in the same cycle, including an output held in OUT; the pending word is dropped.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-033 Reset, then in_valid with y = 16'h0400, ybar = 16'hFBFF -> the next cycle gives out_valid = 1, q = 4'hA, qbar = 4'h5, held for 3 cycles with out_ready = 0.
REQ-034 From REQ-033, out_ready = 1 for one edge, then y = ybar = 16'h0000 -> q = qbar = 0 and out_valid = 0, then IDLE; the next codeword y = 16'h0001, ybar = 16'hFFFE gives q = 4'h0, qbar = 4'hF.
REQ-035 IDLE, y = 16'h0003, ybar = 16'hFFFC -> one err pulse, err_cnt = 1, out_valid stays 0; y = 16'h0010, ybar = 16'h0010 -> err, err_cnt = 2.
REQ-036 REQUIRE_SPACER = 1: after output consumption, apply codeword y = 16'h8000 without a spacer -> err, state stays SPACER, and no output follows until a spacer is accepted.
REQ-037 300 consecutive INVALID transfers -> err_cnt = 8'hFF after the 255th and stays there; err pulses on every transfer.
REQ-038 RN = 0 while in OUT with q = 4'h7 -> the next cycle gives out_valid = 0, q = qbar = 0, err_cnt = 0, and in_ready = 1 after release.
